// File: rtl/cmp_pkg.sv
// Shared definitions for the sequential chunked comparator.
// Holds the controller state encoding and the default operand/chunk widths.
package cmp_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_CHUNK = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } cmpState_t;

endpackage

// File: rtl/seq_comparator_chunk_cmp.sv
// Combinational unsigned compare of one CHUNK-bit slice of each operand.
module chunk_cmp
    import cmp_pkg::*;
#(
    parameter int CHUNK = DEFAULT_CHUNK
) (
    input  logic [CHUNK-1:0] chunkA,
    input  logic [CHUNK-1:0] chunkB,
    output logic             isLt,
    output logic             isEq
);

    assign isLt = (chunkA < chunkB);
    assign isEq = (chunkA == chunkB);

endmodule

// File: rtl/seq_comparator.sv
// Sequential magnitude comparator: examines one CHUNK-bit slice per cycle, MSB slice first.
// SEQ_CMP_EARLY_EXIT_EN defined: stop at the first differing slice; undefined: always scan all slices.
module seq_comparator
    import cmp_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CHUNK = DEFAULT_CHUNK
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             signed_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             isLessThan,
    output logic             isNotEqual,
    output logic             isGreaterThan
);

    localparam int N  = WIDTH / CHUNK;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    // Flipping the sign bit maps two's-complement order onto unsigned order.
    localparam logic [WIDTH-1:0] SIGN_MASK = WIDTH'(1) << (WIDTH - 1);

    cmpState_t        state;
    logic [KW-1:0]    kReg;
    logic [WIDTH-1:0] opAReg;
    logic [WIDTH-1:0] opBReg;

    logic [CHUNK-1:0] chunkA [N];
    logic [CHUNK-1:0] chunkB [N];
    logic             chunkLt;
    logic             chunkEq;

    for (genvar gi = 0; gi < N; gi++) begin : gSlice
        assign chunkA[gi] = opAReg[gi*CHUNK +: CHUNK];
        assign chunkB[gi] = opBReg[gi*CHUNK +: CHUNK];
    end

    chunk_cmp #(
        .CHUNK (CHUNK)
    ) uChunkCmp (
        .chunkA (chunkA[kReg]),
        .chunkB (chunkB[kReg]),
        .isLt   (chunkLt),
        .isEq   (chunkEq)
    );

    assign in_ready = (state == IDLE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            kReg          <= '0;
            opAReg        <= '0;
            opBReg        <= '0;
            out_valid     <= 1'b0;
            isLessThan    <= 1'b0;
            isNotEqual    <= 1'b0;
            isGreaterThan <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        opAReg        <= data_operandA ^ (signed_mode ? SIGN_MASK : '0);
                        opBReg        <= data_operandB ^ (signed_mode ? SIGN_MASK : '0);
                        kReg          <= KW'(N - 1);
                        isLessThan    <= 1'b0;
                        isNotEqual    <= 1'b0;
                        isGreaterThan <= 1'b0;
                        state         <= CMP;
                    end
                end
                CMP: begin
`ifdef SEQ_CMP_EARLY_EXIT_EN
                    if (!chunkEq) begin
                        isLessThan    <= chunkLt;
                        isGreaterThan <= !chunkLt;
                        isNotEqual    <= 1'b1;
                        out_valid     <= 1'b1;
                        state         <= DONE;
                    end else if (kReg == '0) begin
                        out_valid     <= 1'b1;
                        state         <= DONE;
                    end else begin
                        kReg <= kReg - 1'b1;
                    end
`else
                    // isNotEqual doubles as the "already decided" flag for the full scan.
                    if (!isNotEqual && !chunkEq) begin
                        isLessThan    <= chunkLt;
                        isGreaterThan <= !chunkLt;
                        isNotEqual    <= 1'b1;
                    end
                    if (kReg == '0) begin
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        kReg <= kReg - 1'b1;
                    end
`endif
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_comparator.sv
// Randomized self-checking bench for seq_comparator against an arithmetic reference model.
// Latency expectations follow SEQ_CMP_EARLY_EXIT_EN the same way the design build does.
module tb_seq_comparator;

    localparam int WIDTH = 32;
    localparam int CHUNK = 8;
    localparam int N     = WIDTH / CHUNK;

    logic             clock;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic             signed_mode;
    logic             out_valid;
    logic             out_ready;
    logic             isLessThan;
    logic             isNotEqual;
    logic             isGreaterThan;

    int nChecks = 0;
    int nPassed = 0;

    seq_comparator #(
        .WIDTH (WIDTH),
        .CHUNK (CHUNK)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .data_operandA (data_operandA),
        .data_operandB (data_operandB),
        .signed_mode   (signed_mode),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .isLessThan    (isLessThan),
        .isNotEqual    (isNotEqual),
        .isGreaterThan (isGreaterThan)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got === exp) nPassed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference: chunks examined = slices down to and including the most significant differing one.
    function automatic int expLatency(input logic [31:0] a, input logic [31:0] b);
`ifdef SEQ_CMP_EARLY_EXIT_EN
        logic [31:0] diff;
        diff = a ^ b;
        for (int p = WIDTH - 1; p >= 0; p--)
            if (diff[p]) return N - (p / CHUNK);
        return N;
`else
        return N;
`endif
    endfunction

    function automatic logic [2:0] expFlags(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic lt, gt;
        if (s) begin
            lt = $signed(a) < $signed(b);
            gt = $signed(a) > $signed(b);
        end else begin
            lt = a < b;
            gt = a > b;
        end
        return {lt, a != b, gt};
    endfunction

    // Present one operand set at a negedge; returns on the negedge after the accept edge.
    task automatic startOp(input logic [31:0] a, input logic [31:0] b, input logic s);
        @(negedge clock);
        in_valid      = 1'b1;
        data_operandA = a;
        data_operandB = b;
        signed_mode   = s;
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    // Called on the negedge right after the accept edge; holds out_ready low for `hold` cycles.
    task automatic waitResult(input logic [31:0] a, input logic [31:0] b, input logic s,
                              input int hold, input logic pushNext, input string tag);
        int cnt;
        logic [3:0] snap;
        cnt = 0;
        checkVal({tag, "_busy_ready"}, 32'(in_ready), 32'd0);
        while (!out_valid && cnt < 64) begin
            @(negedge clock);
            cnt++;
        end
        checkVal({tag, "_latency"}, 32'(cnt), 32'(expLatency(a, b)));
        checkVal({tag, "_flags"}, 32'({isLessThan, isNotEqual, isGreaterThan}), 32'(expFlags(a, b, s)));
        snap = {out_valid, isLessThan, isNotEqual, isGreaterThan};
        if (pushNext) begin
            in_valid      = 1'b1;
            data_operandA = 32'hFFFF_0000;
            data_operandB = 32'h0000_FFFF;
            signed_mode   = 1'b1;
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clock);
            checkVal({tag, "_hold_stable"}, 32'({out_valid, isLessThan, isNotEqual, isGreaterThan}), 32'(snap));
            checkVal({tag, "_hold_ready"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
        checkVal({tag, "_drop_valid"}, 32'(out_valid), 32'd0);
        checkVal({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
        $display("op %s A=%08h B=%08h s=%0d latency=%0d flags=%03b", tag, a, b, s, cnt,
                 {isLessThan, isNotEqual, isGreaterThan});
    endtask

    initial begin
        logic [31:0] a, b;
        logic        s;
        int          c;
        bit          sawValid;

        reset         = 1'b0;
        in_valid      = 1'b0;
        out_ready     = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        signed_mode   = 1'b0;
        #1;
        checkVal("reset_ready", 32'(in_ready), 32'd1);
        checkVal("reset_outs", 32'({out_valid, isLessThan, isNotEqual, isGreaterThan}), 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b1;

        startOp(32'd5, 32'd7, 1'b0);
        waitResult(32'd5, 32'd7, 1'b0, 0, 1'b0, "u5lt7");
        startOp(32'hFFFF_FFFF, 32'd1, 1'b1);
        waitResult(32'hFFFF_FFFF, 32'd1, 1'b1, 0, 1'b0, "s_m1_vs_1");
        startOp(32'hFFFF_FFFF, 32'd1, 1'b0);
        waitResult(32'hFFFF_FFFF, 32'd1, 1'b0, 0, 1'b0, "u_max_vs_1");
        startOp(32'h1234_5678, 32'h1234_5678, 1'b0);
        waitResult(32'h1234_5678, 32'h1234_5678, 1'b0, 0, 1'b0, "equal");

        // Backpressure with a second operand set waiting: accepted only once back in IDLE.
        startOp(32'd5, 32'd7, 1'b0);
        waitResult(32'd5, 32'd7, 1'b0, 3, 1'b1, "hold");
        @(negedge clock);
        in_valid = 1'b0;
        waitResult(32'hFFFF_0000, 32'h0000_FFFF, 1'b1, 0, 1'b0, "queued");

        // Reset two cycles into a compare discards it.
        startOp(32'd5, 32'd7, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        checkVal("midreset_ready", 32'(in_ready), 32'd1);
        checkVal("midreset_outs", 32'({out_valid, isLessThan, isNotEqual, isGreaterThan}), 32'd0);
        @(negedge clock);
        reset     = 1'b1;
        out_ready = 1'b0;
        sawValid  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            if (out_valid) sawValid = 1'b1;
        end
        checkVal("midreset_no_result", 32'(sawValid), 32'd0);
        checkVal("midreset_idle", 32'(in_ready), 32'd1);

        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            c = $urandom_range(0, 5);
            if (c == 4)      b = a;
            else if (c == 5) b = $urandom;
            else             b = a ^ (32'($urandom_range(1, 255)) << (c * CHUNK));
            s = 1'($urandom_range(0, 1));
            startOp(a, b, s);
            waitResult(a, b, s, $urandom_range(0, 2), 1'b0, $sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", nPassed, nChecks);
        $finish;
    end

endmodule

// File: doc/seq_comparator.md
SEQ_COMPARATOR -- requirements
Module: seq_comparator

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits.
REQ-002 SHALL have parameter CHUNK, default 8, bits compared per cycle; WIDTH mod CHUNK SHALL be 0; N = WIDTH/CHUNK.
REQ-003 SHALL have port clock  input  1  sole clock, rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  operands presented.
REQ-006 SHALL have port in_ready  output  1  block can accept operands.
REQ-007 SHALL have port data_operandA  input  WIDTH  first operand.
REQ-008 SHALL have port data_operandB  input  WIDTH  second operand.
REQ-009 SHALL have port signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; sampled with operands.
REQ-010 SHALL have port out_valid  output  1  result available.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have ports isLessThan, isNotEqual, isGreaterThan  output  1 each  A<B, A!=B, A>B.

Function
REQ-013 SHALL implement states IDLE, CMP, DONE; in_ready = 1 only in IDLE.
REQ-014 SHALL, on in_valid&&in_ready at a rising edge, latch both operands and signed_mode, set chunk index k=N-1, and enter CMP.
REQ-015 SHALL, in CMP, compare chunk k of A and B unsigned, one chunk per cycle, MSB chunk first.
REQ-016 SHALL, when signed_mode=1, invert bit WIDTH-1 of both operands before the chunk-(N-1) compare.
REQ-017 SHALL, on a differing chunk, register lt/gt from that chunk, set isNotEqual=1, and enter DONE (early exit).
REQ-018 SHALL, on an equal chunk with k>0, decrement k and stay in CMP.
REQ-019 SHALL, on an equal chunk with k=0, register isLessThan=0, isGreaterThan=0, isNotEqual=0, and enter DONE.
REQ-020 SHALL set out_valid=1 throughout DONE; result outputs SHALL stay stable while out_valid=1.
REQ-021 Latency SHALL be j cycles from the accept edge to out_valid=1, where j = number of chunks examined (1..N).
REQ-022 SHALL leave DONE for IDLE on out_valid&&out_ready; out_valid SHALL deassert the following cycle.
REQ-023 SHALL ignore in_valid outside IDLE; no overlapping operations; at most one result is outstanding.
REQ-024 Exactly one of isLessThan and isGreaterThan SHALL be 1 when isNotEqual=1; both SHALL be 0 otherwise.

Reset
REQ-025 reset=0 SHALL immediately force state IDLE, k=0, out_valid=0, and all result outputs to 0; in_ready SHALL be 1.
REQ-026 Reset during CMP or DONE SHALL discard the operation; no result SHALL be emitted after release.

Configuration
REQ-027 Macro SEQ_CMP_EARLY_EXIT_EN defined: early exit per REQ-017, giving variable latency 1..N.
REQ-028 Macro SEQ_CMP_EARLY_EXIT_EN undefined: CMP SHALL always scan all N chunks, recording the result at the first differing chunk and ignoring later ones, giving a fixed latency of N.

Structure
REQ-029 Package cmp_pkg SHALL hold the state enum and the WIDTH/CHUNK defaults.
REQ-030 Sub-module chunk_cmp (combinational, CHUNK-bit unsigned lt/eq) SHALL be instantiated once and muxed by k.

Verification (WIDTH=32, CHUNK=8, macro defined unless stated)
REQ-031 Unsigned A=5, B=7 -> out_valid 4 cycles after accept; lt=1, ne=1, gt=0.
REQ-032 Signed A=0xFFFFFFFF, B=1 -> latency 1; lt=1, gt=0. Same operands unsigned -> latency 1; gt=1, lt=0.
REQ-033 A=B=0x12345678 -> latency 4; lt=0, ne=0, gt=0.
REQ-034 Hold out_ready=0 for 3 cycles in DONE while in_valid=1 -> outputs stable, in_ready=0, second operand set not accepted; accept on first edge after return to IDLE.
REQ-035 Assert reset 2 cycles into an A=5, B=7 compare -> outputs 0 and in_ready=1 immediately; no out_valid after release.
REQ-036 Macro undefined, signed A=0xFFFFFFFF, B=1 -> latency 4; lt=1.
